// File: rtl/hci_core_memmap_demux.sv
// Address-decoding demultiplexer: one HCI slave port fanned out to NB_OUT master ports,
// with in-order response tracking and an internal error responder for unmapped addresses.
module hci_core_memmap_demux #(
   parameter int          NB_REGION       = 4,
   parameter int          NB_OUT          = 2,
   parameter int          AW              = 32,
   parameter int          DW              = 32,
   parameter int          MAX_OUTSTANDING = 4,
   parameter logic [31:0] ERR_DATA        = 32'hbadacce5,
   localparam int         PW              = (NB_OUT > 1) ? $clog2(NB_OUT) : 1,
   localparam int         CW              = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             clear_i,
   input  logic [NB_REGION-1:0][AW-1:0]     region_start_addr_i,
   input  logic [NB_REGION-1:0][AW-1:0]     region_end_addr_i,
   input  logic [NB_REGION-1:0][PW-1:0]     region_port_i,
   input  logic [NB_REGION-1:0]             region_en_i,
   input  logic                             s_req_i,
   output logic                             s_gnt_o,
   input  logic [AW-1:0]                    s_add_i,
   input  logic                             s_wen_i,
   input  logic [DW-1:0]                    s_data_i,
   input  logic [DW/8-1:0]                  s_be_i,
   output logic                             s_r_valid_o,
   output logic [DW-1:0]                    s_r_data_o,
   output logic                             s_r_opc_o,
   output logic [NB_OUT-1:0]                m_req_o,
   input  logic [NB_OUT-1:0]                m_gnt_i,
   output logic [NB_OUT-1:0][AW-1:0]        m_add_o,
   output logic [NB_OUT-1:0]                m_wen_o,
   output logic [NB_OUT-1:0][DW-1:0]        m_data_o,
   output logic [NB_OUT-1:0][DW/8-1:0]      m_be_o,
   input  logic [NB_OUT-1:0]                m_r_valid_i,
   input  logic [NB_OUT-1:0][DW-1:0]        m_r_data_i,
   input  logic [NB_OUT-1:0]                m_r_opc_i,
   output logic                             err_o,
   output logic [CW-1:0]                    outstanding_o
);

   localparam int                DEST_W   = $clog2(NB_OUT + 1);
   localparam logic [DEST_W-1:0] DEST_ERR = DEST_W'(NB_OUT);
   localparam int                ERR_REP  = (DW + 31) / 32;
   localparam logic [ERR_REP*32-1:0] ERR_WIDE = {ERR_REP{ERR_DATA}};
   localparam logic [DW-1:0]     ERR_WORD = ERR_WIDE[DW-1:0];

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [DEST_W-1:0] r_cur_dest;
   logic              r_err_pending;

   logic              w_active;
   logic              w_hit;
   logic [DEST_W-1:0] w_dest;
   logic              w_dest_err;
   logic              w_stall;
   logic              w_gnt_sel;
   logic              w_accept;
   logic [CW-1:0]     w_cnt_next;

   // Reset and soft clear also mask the combinational outputs while they are held.
   assign w_active = rst_ni & ~clear_i;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_dest = DEST_ERR;
      w_hit  = 1'b0;
      for (int i = 0; i < NB_REGION; i++) begin
         if (!w_hit && region_en_i[i] &&
             s_add_i >= region_start_addr_i[i] && s_add_i < region_end_addr_i[i]) begin
            w_hit = 1'b1;
            if (int'(region_port_i[i]) < NB_OUT) w_dest = DEST_W'(region_port_i[i]);
         end
      end
   end

   assign w_dest_err = (w_dest == DEST_ERR);
   // Only one destination may be in flight so responses come back in order.
   assign w_stall    = (r_cnt == CW'(MAX_OUTSTANDING)) ||
                       ((r_cnt != '0) && (w_dest != r_cur_dest));

   always_comb begin
      m_req_o   = '0;
      w_gnt_sel = 1'b0;
      for (int p = 0; p < NB_OUT; p++) begin
         m_req_o[p]  = w_active & s_req_i & (w_dest == DEST_W'(p)) & ~w_stall;
         if (w_dest == DEST_W'(p)) w_gnt_sel = m_gnt_i[p];
         m_add_o[p]  = s_add_i;
         m_wen_o[p]  = s_wen_i;
         m_data_o[p] = s_data_i;
         m_be_o[p]   = s_be_i;
      end
      s_gnt_o  = w_dest_err ? (w_active & s_req_i & ~w_stall) : (w_gnt_sel & (|m_req_o));
      w_accept = s_req_i & s_gnt_o;
   end

   always_comb begin
      s_r_valid_o = 1'b0;
      s_r_data_o  = '0;
      s_r_opc_o   = 1'b0;
      if (w_active && r_err_pending) begin
         s_r_valid_o = 1'b1;
         s_r_data_o  = ERR_WORD;
         s_r_opc_o   = 1'b1;
      end else if (w_active && r_state == BUSY) begin
         for (int p = 0; p < NB_OUT; p++) begin
            if (r_cur_dest == DEST_W'(p) && m_r_valid_i[p]) begin
               s_r_valid_o = 1'b1;
               s_r_data_o  = m_r_data_i[p];
               s_r_opc_o   = m_r_opc_i[p];
            end
         end
      end
   end

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_accept && !s_r_valid_o)      w_cnt_next = r_cnt + CW'(1);
      else if (!w_accept && s_r_valid_o) w_cnt_next = r_cnt - CW'(1);
   end

   assign err_o         = w_active & r_err_pending;
   assign outstanding_o = w_active ? r_cnt : '0;

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous.
      if (!rst_ni || clear_i) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_cur_dest    <= '0;
         r_err_pending <= 1'b0;
      end else begin
         r_cnt         <= w_cnt_next;
         r_err_pending <= w_accept & w_dest_err;
         if (w_accept) r_cur_dest <= w_dest;
         unique case (r_state)
            IDLE:    if (w_accept) r_state <= BUSY;
            BUSY:    if (w_cnt_next == '0) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
